serial_packet_receiver: RTL and testbench

Deserializer for the single-wire packet link driven by the 40-bit packet sender. It detects the start bit and shifts in 40 data bits MSB-first. It enforces the inter-packet gap and delivers each word through a 2-entry output FIFO with a valid/ready handshake. Audio-sample-request packets are flagged on a dedicated strobe.

---
 rtl/serial_packet_receiver.sv | 177 +++++++++++++++++
 tb/tb_serial_packet_receiver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_packet_receiver.sv
// Serial packet receiver: start-bit framed 40-bit words, MSB first.
// Guard-gap checking, audio-request strobe, 2-deep output FIFO.
module serial_packet_receiver #(
  parameter int          SYNC_STAGES      = 2,
  parameter int          MIN_GAP          = 3,
  parameter logic [39:0] AUDIO_REQ_WORD   = 40'h0700000000,
  parameter bit          FILTER_AUDIO_REQ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [39:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        audio_req,
  output logic        overrun,
  output logic        gap_error
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;
  localparam logic [1:0] ST_RESYNC = 2'd3;

  localparam logic [7:0] GAP_LAST  = 8'(MIN_GAP - 1);
  localparam logic [5:0] BIT_LAST  = 6'd39;

  logic        w_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = sin;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;

      // Synchronizer chain on the serial input
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= sin;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
          end
        end
      end

      assign w_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  logic [1:0]  r_state;
  logic [5:0]  r_bitcnt;
  logic [39:0] r_shift;
  logic [7:0]  r_gapcnt;

  logic [39:0] r_mem [2];
  logic        r_rd;
  logic        r_wr;
  logic [1:0]  r_cnt;

  logic        r_audio_req;
  logic        r_overrun;
  logic        r_gap_error;

  logic        w_last_bit;
  logic [39:0] w_word;
  logic        w_is_audio;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_wr_en;
  logic        w_gap_done;

  // The word is complete in the same edge that shifts its last bit in
  assign w_last_bit = (r_state == ST_DATA) && (r_bitcnt == BIT_LAST);
  assign w_word     = {r_shift[38:0], w_s};
  assign w_is_audio = (w_word == AUDIO_REQ_WORD);
  assign w_push     = w_last_bit && !(FILTER_AUDIO_REQ && w_is_audio);
  assign w_full     = (r_cnt == 2'd2);
  assign w_pop      = out_valid && out_ready;
  assign w_wr_en    = w_push && (!w_full || w_pop);
  assign w_gap_done = !w_s && (r_gapcnt == GAP_LAST);

  // Framing FSM: start detect, data shift, guard gap, resync
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_gapcnt <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_s) begin
            r_state  <= ST_DATA;
            r_bitcnt <= '0;
          end
        end
        ST_DATA: begin
          r_shift  <= w_word;
          r_bitcnt <= r_bitcnt + 6'd1;
          if (w_last_bit) begin
            r_state  <= (MIN_GAP == 0) ? ST_IDLE : ST_GAP;
            r_gapcnt <= '0;
          end
        end
        ST_GAP: begin
          if (w_s) begin
            r_state  <= ST_RESYNC;
            r_gapcnt <= '0;
          end else if (w_gap_done) begin
            r_state  <= ST_IDLE;
          end else begin
            r_gapcnt <= r_gapcnt + 8'd1;
          end
        end
        ST_RESYNC: begin
          if (w_s) begin
            r_gapcnt <= '0;
          end else if (w_gap_done) begin
            r_state  <= ST_IDLE;
          end else begin
            r_gapcnt <= r_gapcnt + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // One-cycle status strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_audio_req <= 1'b0;
      r_overrun   <= 1'b0;
      r_gap_error <= 1'b0;
    end else begin
      r_audio_req <= w_last_bit && w_is_audio;
      r_overrun   <= w_push && w_full && !w_pop;
      r_gap_error <= (r_state == ST_GAP) && w_s;
    end
  end

  // Two-entry FIFO; a push into a full FIFO only lands if the head leaves
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr] <= w_word;
        r_wr        <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      if (w_wr_en && !w_pop) begin
        r_cnt <= r_cnt + 2'd1;
      end else if (!w_wr_en && w_pop) begin
        r_cnt <= r_cnt - 2'd1;
      end
    end
  end

  assign out_valid = (r_cnt != 2'd0);
  assign out_data  = out_valid ? r_mem[r_rd] : '0;
  assign audio_req = r_audio_req;
  assign overrun   = r_overrun;
  assign gap_error = r_gap_error;

endmodule

// File: tb/tb_serial_packet_receiver.sv
// Scoreboard bench for serial_packet_receiver.
// Two instances: audio filtering on (a) and off (b).
module tb_serial_packet_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sin;
  logic        out_ready;
  logic [39:0] da, db;
  logic        va, vb, aa, ab, oa, ob, ga, gb;

  localparam logic [39:0] W91 = 40'hD999999991;
  localparam logic [39:0] W93 = 40'hD999999993;
  localparam logic [39:0] W95 = 40'hD999999995;
  localparam logic [39:0] AUD = 40'h0700000000;
  localparam logic [39:0] W9A = 40'h123456789A;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  serial_packet_receiver dut_a (
    .clk(clk), .rst_n(rst_n), .sin(sin),
    .out_data(da), .out_valid(va), .out_ready(out_ready),
    .audio_req(aa), .overrun(oa), .gap_error(ga)
  );

  serial_packet_receiver #(.FILTER_AUDIO_REQ(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .sin(sin),
    .out_data(db), .out_valid(vb), .out_ready(out_ready),
    .audio_req(ab), .overrun(ob), .gap_error(gb)
  );

  typedef struct {
    logic [39:0] d;
    int          c;
  } wexp_t;

  wexp_t wq [2][$];
  int    pq [6][$];
  int    checks = 0;
  int    fails  = 0;

  string pn [6] = '{"audio_req_a", "overrun_a", "gap_error_a",
                    "audio_req_b", "overrun_b", "gap_error_b"};

  // Monitor: pops expectations whenever a DUT presents a word or pulse
  always @(negedge clk) begin
    logic [39:0] dd [2];
    logic        vv [2];
    logic        pp [6];
    wexp_t       e;
    int          ec;
    dd[0] = da; dd[1] = db;
    vv[0] = va; vv[1] = vb;
    pp[0] = aa; pp[1] = oa; pp[2] = ga;
    pp[3] = ab; pp[4] = ob; pp[5] = gb;
    for (int d = 0; d < 2; d++) begin
      if (vv[d] && out_ready) begin
        checks++;
        if (wq[d].size() == 0) begin
          fails++;
          $display("FAIL word_%0d unexpected actual=%h cyc=%0d required=none",
                   d, dd[d], cyc);
        end else begin
          e = wq[d].pop_front();
          if (dd[d] !== e.d || (e.c >= 0 && e.c != cyc)) begin
            fails++;
            $display("FAIL word_%0d actual=%h@%0d required=%h@%0d",
                     d, dd[d], cyc, e.d, e.c);
          end
        end
      end
    end
    for (int k = 0; k < 6; k++) begin
      if (pp[k] === 1'b1) begin
        checks++;
        if (pq[k].size() == 0) begin
          fails++;
          $display("FAIL %s unexpected pulse cyc=%0d required=none",
                   pn[k], cyc);
        end else begin
          ec = pq[k].pop_front();
          if (ec != cyc) begin
            fails++;
            $display("FAIL %s actual_cyc=%0d required_cyc=%0d",
                     pn[k], cyc, ec);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bit1(input logic b);
    sin = b;
    tick(1);
  endtask

  task automatic send(input logic [39:0] w, input int zeros);
    bit1(1'b1);
    for (int i = 39; i >= 0; i--) bit1(w[i]);
    repeat (zeros) bit1(1'b0);
  endtask

  task automatic exp_word(input int m, input logic [39:0] w,
                          input int c);
    wexp_t e;
    e.d = w;
    e.c = c;
    if (m[0]) wq[0].push_back(e);
    if (m[1]) wq[1].push_back(e);
  endtask

  task automatic exp_pulse(input int k, input int c);
    pq[k].push_back(c);
    pq[k+3].push_back(c);
  endtask

  task automatic chk1(input string nm, input logic [39:0] act,
                      input logic [39:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_data_a"},  da, 40'd0);
    chk1({tag, "_valid_a"}, {39'd0, va}, 40'd0);
    chk1({tag, "_audio_a"}, {39'd0, aa}, 40'd0);
    chk1({tag, "_ovr_a"},   {39'd0, oa}, 40'd0);
    chk1({tag, "_gap_a"},   {39'd0, ga}, 40'd0);
    chk1({tag, "_data_b"},  db, 40'd0);
    chk1({tag, "_valid_b"}, {39'd0, vb}, 40'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    logic [39:0] part;
    rst_n     = 1'b0;
    sin       = 1'b0;
    out_ready = 1'b0;
    tick(3);
    chk_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // single packet, consumer ready
    out_ready = 1'b1;
    p = cyc;
    exp_word(3, W91, p + 43);
    send(W91, 4);
    tick(10);

    // back-to-back into stalled FIFO, third one overruns
    out_ready = 1'b0;
    exp_word(3, W91, -1);
    send(W91, 4);
    exp_word(3, W93, -1);
    send(W93, 4);
    p = cyc;
    exp_pulse(1, p + 43);
    send(W95, 4);
    tick(5);
    chk1("hold_head_a", da, W91);
    chk1("hold_valid_a", {39'd0, va}, 40'd1);
    chk1("hold_head_b", db, W91);
    out_ready = 1'b1;
    p = cyc;
    tick(1);
    chk1("refill_data_a", da, W93);
    chk1("refill_valid_a", {39'd0, va}, 40'd1);
    tick(5);

    // audio request: filtered in a, pushed in b
    p = cyc;
    exp_pulse(0, p + 43);
    exp_word(2, AUD, p + 43);
    send(AUD, 4);
    tick(5);

    // gap violation then a clean packet after resync
    p = cyc;
    exp_word(3, W91, p + 43);
    exp_pulse(2, p + 44);
    send(W91, 0);
    bit1(1'b1);
    bit1(1'b0);
    bit1(1'b0);
    bit1(1'b0);
    p = cyc;
    exp_word(3, W93, p + 43);
    send(W93, 4);
    tick(5);

    // reset in the middle of a packet
    part = W95;
    bit1(1'b1);
    for (int i = 39; i >= 20; i--) bit1(part[i]);
    sin   = 1'b0;
    rst_n = 1'b0;
    tick(3);
    chk_zero("midrst");
    rst_n = 1'b1;
    tick(3);
    p = cyc;
    exp_word(3, W9A, p + 43);
    send(W9A, 4);
    tick(10);

    for (int d = 0; d < 2; d++) begin
      checks++;
      if (wq[d].size() != 0) begin
        fails++;
        $display("FAIL word_%0d_pending actual=%0d required=0",
                 d, wq[d].size());
      end
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (pq[k].size() != 0) begin
        fails++;
        $display("FAIL %s_pending actual=%0d required=0",
                 pn[k], pq[k].size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
